// File: rtl/pcie_phy_pkg.sv
// Shared PHY definitions: 8b/10b comma codes, symbol width and RX alignment states.
package pcie_phy_pkg;

    localparam int SYMBOL_WIDTH = 10;

    localparam logic [SYMBOL_WIDTH-1:0] K28_5_RDN = 10'h17C;
    localparam logic [SYMBOL_WIDTH-1:0] K28_5_RDP = 10'h283;

    typedef enum logic [1:0] {
        UNALIGNED,
        ACQUIRE,
        LOCKED
    } rx_align_state_t;

endpackage

// File: rtl/pcie_comma_detect.sv
// Combinational K28.5 match (either running disparity) on a 10-bit window.
module pcie_comma_detect
    import pcie_phy_pkg::*;
(
    input  logic [SYMBOL_WIDTH-1:0] symbol,
    output logic                    is_comma
);

    assign is_comma = (symbol == K28_5_RDN) || (symbol == K28_5_RDP);

endmodule

// File: rtl/pcie_rx_symbol_aligner.sv
// Per-lane RX symbol aligner: finds K28.5 boundaries in the serial stream and emits aligned symbols.
// Optional RX_ALIGN_STATS_EN adds realign_count_o (saturating lock-loss + ACQUIRE realign count).
module pcie_rx_symbol_aligner
    import pcie_phy_pkg::*;
#(
    parameter int LOCK_COMMAS = 4,
    parameter int UNLOCK_ERRS = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    lane_enable_i,
    input  logic                    rx_bit_i,
    input  logic                    rx_bit_valid_i,
    output logic [SYMBOL_WIDTH-1:0] symbol_o,
    output logic                    symbol_valid_o,
    output logic                    symbol_is_comma_o,
    output logic                    rx_locked_o,
    output logic                    lock_lost_o
`ifdef RX_ALIGN_STATS_EN
   ,output logic [15:0]             realign_count_o
`endif
);

    localparam logic [2:0] LC3 = 3'(LOCK_COMMAS);

    rx_align_state_t         state, state_nxt;
    logic [SYMBOL_WIDTH-1:0] sr, sr_nxt;
    logic [3:0]              ph, ph_nxt;
    logic [2:0]              cnt, cnt_nxt, err, err_nxt;
    logic                    comma, boundary, emit, lost;

    assign sr_nxt   = {rx_bit_i, sr[SYMBOL_WIDTH-1:1]};
    assign boundary = (ph == 4'd9);

    pcie_comma_detect u_comma (
        .symbol   (sr_nxt),
        .is_comma (comma)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i || !lane_enable_i) state <= UNALIGNED;
        else                         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ph_nxt    = ph;
        cnt_nxt   = cnt;
        err_nxt   = err;
        emit      = 1'b0;
        lost      = 1'b0;
        if (rx_bit_valid_i) begin
            ph_nxt = boundary ? 4'd0 : ph + 4'd1;
            unique case (state)
                UNALIGNED: begin
                    if (comma) begin
                        ph_nxt    = 4'd0;
                        cnt_nxt   = 3'd1;
                        state_nxt = (LOCK_COMMAS == 1) ? LOCKED : ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (boundary) begin
                        if (comma) begin
                            cnt_nxt = (cnt >= LC3) ? LC3 : cnt + 3'd1;
                            if ({1'b0, cnt} + 4'd1 >= 4'(LOCK_COMMAS)) state_nxt = LOCKED;
                        end else begin
                            cnt_nxt   = 3'd0;
                            state_nxt = UNALIGNED;
                        end
                    end else if (comma) begin
                        ph_nxt  = 4'd0;
                        cnt_nxt = 3'd1;
                    end
                end
                LOCKED: begin
                    if (boundary) begin
                        emit = 1'b1;
                        if (comma) err_nxt = 3'd0;
                    end else if (comma) begin
                        // Misplaced commas are counted but never used to realign while locked.
                        if ({1'b0, err} + 4'd1 >= 4'(UNLOCK_ERRS)) begin
                            err_nxt   = 3'd0;
                            lost      = 1'b1;
                            state_nxt = UNALIGNED;
                        end else begin
                            err_nxt = err + 3'd1;
                        end
                    end
                end
                default: state_nxt = UNALIGNED;
            endcase
        end
    end

    // symbol_o / symbol_is_comma_o hold their last emitted value between strobes.
    always_ff @(posedge clk_i) begin
        if (rst_i || !lane_enable_i) begin
            sr                <= '0;
            ph                <= '0;
            cnt               <= '0;
            err               <= '0;
            symbol_o          <= '0;
            symbol_valid_o    <= 1'b0;
            symbol_is_comma_o <= 1'b0;
            lock_lost_o       <= 1'b0;
        end else begin
            ph             <= ph_nxt;
            cnt            <= cnt_nxt;
            err            <= err_nxt;
            symbol_valid_o <= emit;
            lock_lost_o    <= lost;
            if (rx_bit_valid_i) sr <= sr_nxt;
            if (emit) begin
                symbol_o          <= sr_nxt;
                symbol_is_comma_o <= comma;
            end
        end
    end

    assign rx_locked_o = (state == LOCKED);

`ifdef RX_ALIGN_STATS_EN
    logic realign_evt;
    assign realign_evt = lane_enable_i && rx_bit_valid_i && (state == ACQUIRE) && !boundary && comma;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            realign_count_o <= '0;
        else if ((realign_evt || (lost && lane_enable_i)) && realign_count_o != 16'hFFFF)
            realign_count_o <= realign_count_o + 16'd1;
    end
`endif

endmodule
